// File: rtl/axi_pkg.sv
// Shared AXI constants for the DDR-side responder: burst types, response codes and beat size.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_16B    = 3'b100;

    // Anything other than full-width FIXED/INCR beats is answered with SLVERR.
    function automatic logic unsupported_req(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_16B) || (burst == BURST_WRAP) || (burst == 2'b11);
    endfunction

endpackage

// File: rtl/axi_ddr_responder_if.sv
// 128-bit AXI4 port between the DRAM controller (master) and the on-chip responder (slave).
interface axi_ddr_responder_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

endinterface

// File: rtl/axi_resp_ram.sv
// Simple dual-port RAM with byte-enabled writes and a registered, read-first read port.
module axi_resp_ram #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [MASK_WIDTH-1:0] wbe,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Write and read share one block so a same-cycle collision returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_ddr_responder.sv
// AXI4 slave standing in for the MIG: answers the DRAM controller's 128-bit port from on-chip RAM.
module axi_ddr_responder
    import axi_pkg::*;
#(
    parameter int APP_ADDR_WIDTH = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16,
    parameter int MEM_WORDS_LOG2 = 14
) (
    input  logic                ui_clk,
    input  logic                ui_rst,
    axi_ddr_responder_if.slave  s_axi
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic R_IDLE = 1'b0;
    localparam logic R_DATA = 1'b1;

    logic [1:0]                w_state, w_state_next;
    logic                      awready_q, wready_q, bvalid_q;
    logic [3:0]                w_id;
    logic [MEM_WORDS_LOG2-1:0] w_addr;
    logic [7:0]                w_len;
    logic [8:0]                w_count;
    logic                      w_fixed, w_err;
    logic                      aw_fire, w_fire, b_fire;
    logic                      w_in_range, w_beat_err, ram_we;

    logic                      r_state, r_state_next;
    logic                      arready_q, rvalid_q;
    logic [3:0]                r_id;
    logic [MEM_WORDS_LOG2-1:0] r_addr, r_next_addr, ram_raddr;
    logic [7:0]                r_len, r_count;
    logic                      r_incr, r_err;
    logic                      ar_fire, r_fire, r_last_beat, ram_re;
    logic [APP_DATA_WIDTH-1:0] ram_q;

    logic                      unused_addr_bits;

    assign unused_addr_bits = &{1'b0,
                                s_axi.awaddr[APP_ADDR_WIDTH-1:MEM_WORDS_LOG2+4], s_axi.awaddr[3:0],
                                s_axi.araddr[APP_ADDR_WIDTH-1:MEM_WORDS_LOG2+4], s_axi.araddr[3:0]};

    assign aw_fire    = s_axi.awvalid && awready_q;
    assign w_fire     = s_axi.wvalid && wready_q;
    assign b_fire     = bvalid_q && s_axi.bready;
    assign w_in_range = (w_count <= {1'b0, w_len});
    assign w_beat_err = !w_in_range || (s_axi.wlast && (w_count != {1'b0, w_len}));
    assign ram_we     = w_fire && w_in_range && !w_err;

    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_fire) w_state_next = W_DATA;
            W_DATA:  if (w_fire && s_axi.wlast) w_state_next = W_RESP;
            W_RESP:  if (b_fire) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next state, so they change exactly on the transition edge.
    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            w_id      <= '0;
            w_addr    <= '0;
            w_len     <= '0;
            w_count   <= '0;
            w_fixed   <= 1'b0;
            w_err     <= 1'b0;
        end else begin
            w_state   <= w_state_next;
            awready_q <= (w_state_next == W_IDLE);
            wready_q  <= (w_state_next == W_DATA);
            bvalid_q  <= (w_state_next == W_RESP);
            if (aw_fire) begin
                w_id    <= s_axi.awid;
                w_addr  <= s_axi.awaddr[MEM_WORDS_LOG2+3:4];
                w_len   <= s_axi.awlen;
                w_count <= '0;
                w_fixed <= (s_axi.awburst == BURST_FIXED);
                w_err   <= unsupported_req(s_axi.awsize, s_axi.awburst);
            end else if (w_fire) begin
                w_count <= w_count + 9'd1;
                if (!w_fixed) begin
                    w_addr <= w_addr + 1'b1;
                end
                if (w_beat_err) begin
                    w_err <= 1'b1;
                end
            end
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bid     = w_id;
    assign s_axi.bresp   = (bvalid_q && w_err) ? RESP_SLVERR : RESP_OKAY;

    assign ar_fire     = s_axi.arvalid && arready_q;
    assign r_fire      = rvalid_q && s_axi.rready;
    assign r_last_beat = (r_count == r_len);
    assign r_next_addr = r_incr ? r_addr + 1'b1 : r_addr;

    // The RAM always looks one beat ahead; it only holds its output while a beat is stalled.
    assign ram_re    = !rvalid_q || s_axi.rready;
    assign ram_raddr = (r_state == R_IDLE) ? s_axi.araddr[MEM_WORDS_LOG2+3:4] : r_next_addr;

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire) r_state_next = R_DATA;
            R_DATA:  if (r_fire && r_last_beat) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_count   <= '0;
            r_incr    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= r_state_next;
            arready_q <= (r_state_next == R_IDLE);
            rvalid_q  <= (r_state_next == R_DATA);
            if (ar_fire) begin
                r_id    <= s_axi.arid;
                r_addr  <= s_axi.araddr[MEM_WORDS_LOG2+3:4];
                r_len   <= s_axi.arlen;
                r_count <= '0;
                r_incr  <= (s_axi.arburst == BURST_INCR);
                r_err   <= unsupported_req(s_axi.arsize, s_axi.arburst);
            end else if (r_fire) begin
                r_count <= r_count + 8'd1;
                r_addr  <= r_next_addr;
            end
        end
    end

    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rid     = r_id;
    assign s_axi.rlast   = rvalid_q && r_last_beat;
    assign s_axi.rresp   = (rvalid_q && r_err) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi.rdata   = (rvalid_q && !r_err) ? ram_q : '0;

    axi_resp_ram #(
        .ADDR_WIDTH (MEM_WORDS_LOG2),
        .DATA_WIDTH (APP_DATA_WIDTH),
        .MASK_WIDTH (APP_MASK_WIDTH)
    ) u_ram (
        .clk   (ui_clk),
        .we    (ram_we),
        .waddr (w_addr),
        .wbe   (s_axi.wstrb),
        .wdata (s_axi.wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

endmodule
